// File: rtl/mfp_srec_word_packer_pkg.sv
// Shared definitions for the S-record write-combining packer.
//   - AHB-Lite codes driven on the loader bus
//   - word_entry_t : one combined word {word address, data, lane mask}
//   - iss_state_t  : bus issuer states
//   - byte_lane()  : byte offset <-> data lane mapping (self-inverse)
//   - first_lane() : lowest set lane of a mask
package mfp_srec_word_packer_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_1       = 3'd0;
    localparam logic [2:0] HSIZE_4       = 3'd2;
    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [3:0] HPROT_DATA    = 4'b0011;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  mask;
    } word_entry_t;

    typedef enum logic [1:0] {
        ISS_IDLE,
        ISS_ADDR,
        ISS_DATA
    } iss_state_t;

    // Big-endian maps offset k to lane 3-k; the mapping is its own inverse,
    // so the same helper turns a lane back into a byte offset.
    function automatic logic [1:0] byte_lane(input logic [1:0] sel, input logic be);
        return be ? ~sel : sel;
    endfunction

    function automatic logic [1:0] first_lane(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

endpackage

// File: rtl/mfp_srec_word_packer_if.sv
// AHB-Lite write-master bus of the loader.
//   master : drives address/control/data, samples HREADY
//   slave  : the multiplexed bus side, drives HREADY
interface mfp_srec_word_packer_if;
    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic        HMASTLOCK;
    logic [3:0]  HPROT;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        HREADY;

    modport master (
        output HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE,
        input  HREADY
    );

    modport slave (
        input  HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE,
        output HREADY
    );
endinterface

// File: rtl/mfp_srec_word_fifo.sv
// Synchronous FIFO of combined word entries.
//   clock, reset : clock, synchronous active-high reset (empties the FIFO)
//   push, push_entry : write request; accepted when not full or when a pop
//                      happens in the same cycle
//   pop, head    : read request and combinational head entry
//   full, empty  : occupancy flags
module mfp_srec_word_fifo
    import mfp_srec_word_packer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        push,
    input  word_entry_t push_entry,
    input  logic        pop,
    output word_entry_t head,
    output logic        full,
    output logic        empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    word_entry_t mem [FIFO_DEPTH];
    logic [AW:0] wptr, rptr;
    logic        do_push, do_pop;

    // Extra pointer bit distinguishes full from empty.
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clock) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_entry;
    end
endmodule

// File: rtl/mfp_srec_word_packer.sv
// Write-combining stage between the S-record parser and the AHB-Lite bus.
//   clock, reset    : HCLK, synchronous active-high reset
//   big_endian      : lane mapping select
//   in_progress     : parser load-active; its falling edge flushes a partial word
//   write_address/byte/enable : parser byte write stream
//   ahb             : AHB-Lite master (single NONSEQ writes, no pipelining)
//   busy            : buffer valid, FIFO non-empty or issuer active
//   overflow        : sticky, a completed word was dropped on a full FIFO
module mfp_srec_word_packer
    import mfp_srec_word_packer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        big_endian,
    input  logic        in_progress,
    input  logic [31:0] write_address,
    input  logic [7:0]  write_byte,
    input  logic        write_enable,
    mfp_srec_word_packer_if.master ahb,
    output logic        busy,
    output logic        overflow
);
    // combining buffer
    logic        buf_valid, buf_valid_nxt;
    logic [29:0] buf_waddr, buf_waddr_nxt;
    logic [31:0] buf_data, buf_data_nxt;
    logic [3:0]  buf_mask, buf_mask_nxt;
    logic        in_progress_q, in_progress_fall;
    logic [1:0]  in_lane;
    logic [31:0] base_data, new_data;
    logic [3:0]  base_mask, new_mask;

    // fifo
    logic        push, pop, fifo_full, fifo_empty;
    word_entry_t push_entry, head;

    // issuer
    iss_state_t  state, state_nxt;
    logic [29:0] iss_waddr;
    logic [31:0] iss_data;
    logic [3:0]  iss_rem;
    logic        iss_full;
    logic [1:0]  cur_lane;
    logic [3:0]  rem_after;

    assign in_progress_fall = in_progress_q && !in_progress;
    assign in_lane          = byte_lane(write_address[1:0], big_endian);

    always_ff @(posedge clock) begin
        if (reset) begin
            in_progress_q <= 1'b0;
            buf_valid     <= 1'b0;
            buf_waddr     <= '0;
            buf_data      <= '0;
            buf_mask      <= '0;
        end else begin
            in_progress_q <= in_progress;
            buf_valid     <= buf_valid_nxt;
            buf_waddr     <= buf_waddr_nxt;
            buf_data      <= buf_data_nxt;
            buf_mask      <= buf_mask_nxt;
        end
    end

    // A word completed by the current strobe goes straight into the FIFO on
    // this edge, so it never sits in the buffer with a full mask. At most one
    // push per cycle: a jump flushes the old word while the new byte can
    // only be a single lane. A strobe coinciding with the in_progress fall
    // takes precedence; the parser stops strobing before dropping the flag.
    always_comb begin
        buf_valid_nxt = buf_valid;
        buf_waddr_nxt = buf_waddr;
        buf_data_nxt  = buf_data;
        buf_mask_nxt  = buf_mask;
        push          = 1'b0;
        push_entry    = '{buf_waddr, buf_data, buf_mask};
        base_data     = '0;
        base_mask     = '0;
        new_data      = '0;
        new_mask      = '0;
        if (write_enable) begin
            if (buf_valid && buf_waddr == write_address[31:2]) begin
                base_data = buf_data;
                base_mask = buf_mask;
            end else if (buf_valid) begin
                push = 1'b1;
            end
            new_data = base_data;
            new_data[{in_lane, 3'b000} +: 8] = write_byte;
            new_mask = base_mask | (4'b0001 << in_lane);
            if (new_mask == 4'hF) begin
                push          = 1'b1;
                push_entry    = '{write_address[31:2], new_data, new_mask};
                buf_valid_nxt = 1'b0;
            end else begin
                buf_valid_nxt = 1'b1;
                buf_waddr_nxt = write_address[31:2];
                buf_data_nxt  = new_data;
                buf_mask_nxt  = new_mask;
            end
        end else if (in_progress_fall && buf_valid) begin
            push          = 1'b1;
            buf_valid_nxt = 1'b0;
        end
    end

    mfp_srec_word_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (reset)
            overflow <= 1'b0;
        else if (push && fifo_full && !pop)
            overflow <= 1'b1;
    end

    // Lanes still to send; the lowest one is the current transfer and stays
    // stable across its address and data phases.
    assign cur_lane  = first_lane(iss_rem);
    assign rem_after = iss_rem & ~(4'b0001 << cur_lane);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ISS_IDLE;
            iss_waddr <= '0;
            iss_data  <= '0;
            iss_rem   <= '0;
            iss_full  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                iss_waddr <= head.waddr;
                iss_data  <= head.data;
                iss_rem   <= head.mask;
                iss_full  <= (head.mask == 4'hF);
            end else if (state == ISS_DATA && ahb.HREADY) begin
                iss_rem <= rem_after;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        pop            = 1'b0;
        ahb.HTRANS     = HTRANS_IDLE;
        ahb.HWRITE     = 1'b0;
        ahb.HADDR      = '0;
        ahb.HSIZE      = HSIZE_1;
        ahb.HWDATA     = '0;
        ahb.HBURST     = HBURST_SINGLE;
        ahb.HMASTLOCK  = 1'b0;
        ahb.HPROT      = HPROT_DATA;
        unique case (state)
            ISS_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ISS_ADDR;
                end
            end
            ISS_ADDR: begin
                ahb.HTRANS = HTRANS_NONSEQ;
                ahb.HWRITE = 1'b1;
                ahb.HSIZE  = iss_full ? HSIZE_4 : HSIZE_1;
                ahb.HADDR  = iss_full ? {iss_waddr, 2'b00}
                                      : {iss_waddr, byte_lane(cur_lane, big_endian)};
                if (ahb.HREADY) state_nxt = ISS_DATA;
            end
            ISS_DATA: begin
                ahb.HWDATA = iss_data;
                if (ahb.HREADY)
                    state_nxt = (iss_full || rem_after == 4'b0000) ? ISS_IDLE : ISS_ADDR;
            end
            default: state_nxt = ISS_IDLE;
        endcase
    end

    assign busy = buf_valid || !fifo_empty || (state != ISS_IDLE);
endmodule

// File: tb/tb_mfp_srec_word_packer.sv
module tb_mfp_srec_word_packer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        big_endian = 1'b0;
    logic        in_progress = 1'b0;
    logic [31:0] write_address = '0;
    logic [7:0]  write_byte = '0;
    logic        write_enable = 1'b0;
    logic        busy, overflow;

    mfp_srec_word_packer_if bus();

    mfp_srec_word_packer #(.FIFO_DEPTH(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .big_endian    (big_endian),
        .in_progress   (in_progress),
        .write_address (write_address),
        .write_byte    (write_byte),
        .write_enable  (write_enable),
        .ahb           (bus),
        .busy          (busy),
        .overflow      (overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
        logic [31:0] dmask;
        logic        wr;
    } xfer_t;

    int          n_checks = 0;
    int          n_fail = 0;
    xfer_t       obs[$];
    xfer_t       exp_q[$];
    logic [31:0] ev_a[$];
    logic [7:0]  ev_d[$];
    logic        mon_ph = 1'b0;
    xfer_t       mon_cur;

    // Bus monitor: records each completed transfer (address phase + data phase).
    always @(negedge clock) begin
        if (reset) begin
            mon_ph <= 1'b0;
        end else if (mon_ph) begin
            if (bus.HREADY) begin
                obs.push_back('{mon_cur.addr, mon_cur.size, bus.HWDATA, 32'hFFFF_FFFF, mon_cur.wr});
                mon_ph <= 1'b0;
            end
        end else if (bus.HTRANS == 2'b10 && bus.HREADY) begin
            mon_cur <= '{bus.HADDR, bus.HSIZE, 32'h0, 32'h0, bus.HWRITE};
            mon_ph  <= 1'b1;
        end
    end

    // Reference: one word's collected bytes become one word write when all four
    // bytes are present, otherwise one byte write per present byte in lane order.
    task automatic emit(input logic [29:0] w, input logic [3:0][7:0] b,
                        input logic [3:0] have, input logic be);
        logic [31:0] d;
        int off;
        if (have == 4'hF) begin
            d = be ? {b[0], b[1], b[2], b[3]} : {b[3], b[2], b[1], b[0]};
            exp_q.push_back('{{w, 2'b00}, 3'd2, d, 32'hFFFF_FFFF, 1'b1});
        end else begin
            for (int lane = 0; lane < 4; lane++) begin
                off = be ? 3 - lane : lane;
                if (have[off]) begin
                    d = 32'(b[off]) << (8 * lane);
                    exp_q.push_back('{{w, 2'(off)}, 3'd0, d, 32'hFF << (8 * lane), 1'b1});
                end
            end
        end
    endtask

    // Groups the recorded byte stream: a word closes when the address leaves it,
    // when all four bytes are present, or when the load ends.
    task automatic model_build(input logic be);
        logic [29:0]      w;
        logic [3:0][7:0]  b;
        logic [3:0]       have;
        logic             open_w;
        w = '0; b = '0; have = '0; open_w = 1'b0;
        for (int i = 0; i < ev_a.size(); i++) begin
            if (open_w && ev_a[i][31:2] != w) begin
                emit(w, b, have, be);
                open_w = 1'b0;
            end
            if (!open_w) begin
                w = ev_a[i][31:2]; b = '0; have = '0; open_w = 1'b1;
            end
            b[ev_a[i][1:0]]    = ev_d[i];
            have[ev_a[i][1:0]] = 1'b1;
            if (have == 4'hF) begin
                emit(w, b, have, be);
                open_w = 1'b0;
            end
        end
        if (open_w) emit(w, b, have, be);
        ev_a.delete();
        ev_d.delete();
    endtask

    task automatic tick(input bit rnd);
        if (rnd) bus.HREADY = ($urandom_range(0, 3) != 0);
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d, input bit rnd);
        write_address = a;
        write_byte    = d;
        write_enable  = 1'b1;
        ev_a.push_back(a);
        ev_d.push_back(d);
        tick(rnd);
        write_enable  = 1'b0;
    endtask

    task automatic drain(input bit rnd, output bit ok);
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            tick(rnd);
        end
        ok = !busy;
        bus.HREADY = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.HREADY = 1'b1;
        tick(0);
        tick(0);
        @(negedge clock);
        n_checks++;
        if (bus.HTRANS !== 2'b00 || bus.HWRITE !== 1'b0 || bus.HADDR !== 32'h0 ||
            bus.HWDATA !== 32'h0 || bus.HSIZE !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_bus: HTRANS=%0d HWRITE=%b HADDR=%h HWDATA=%h HSIZE=%0d, want all zero",
                     bus.HTRANS, bus.HWRITE, bus.HADDR, bus.HWDATA, bus.HSIZE);
        end
        n_checks++;
        if (busy !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy=%b overflow=%b, want 0 0", busy, overflow);
        end
        n_checks++;
        if (bus.HBURST !== 3'd0 || bus.HMASTLOCK !== 1'b0 || bus.HPROT !== 4'b0011) begin
            n_fail++;
            $display("FAIL reset_const: HBURST=%0d HMASTLOCK=%b HPROT=%b, want 0 0 0011",
                     bus.HBURST, bus.HMASTLOCK, bus.HPROT);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick(0);
    endtask

    // Four bytes at 0x100..0x103, zero wait states, cycle-exact timing.
    task automatic test_aligned(input logic be, input logic [31:0] want);
        obs.delete();
        big_endian = be;
        in_progress = 1'b1;
        bus.HREADY = 1'b1;
        wr(32'h100, 8'h11, 0);
        wr(32'h101, 8'h22, 0);
        wr(32'h102, 8'h33, 0);
        wr(32'h103, 8'h44, 0);
        ev_a.delete(); ev_d.delete();
        @(negedge clock);   // cycle 1
        n_checks++;
        if (bus.HTRANS !== 2'b00 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL aligned_be%0d_c1: HTRANS=%0d busy=%b, want 0 1", be, bus.HTRANS, busy);
        end
        @(negedge clock);   // cycle 2
        n_checks++;
        if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h100 || bus.HSIZE !== 3'd2 || bus.HWRITE !== 1'b1) begin
            n_fail++;
            $display("FAIL aligned_be%0d_addr: HTRANS=%0d HADDR=%h HSIZE=%0d HWRITE=%b, want 2 00000100 2 1",
                     be, bus.HTRANS, bus.HADDR, bus.HSIZE, bus.HWRITE);
        end
        @(negedge clock);   // cycle 3
        n_checks++;
        if (bus.HTRANS !== 2'b00 || bus.HWDATA !== want) begin
            n_fail++;
            $display("FAIL aligned_be%0d_data: HTRANS=%0d HWDATA=%h, want 0 %h", be, bus.HTRANS, bus.HWDATA, want);
        end
        @(negedge clock);   // cycle 4
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL aligned_be%0d_busy: busy=%b, want 0", be, busy);
        end
        in_progress = 1'b0;
        tick(0);
        big_endian = 1'b0;
    endtask

    task automatic test_partial();
        bit ok;
        obs.delete();
        in_progress = 1'b1;
        bus.HREADY = 1'b1;
        wr(32'h201, 8'hAA, 0);
        wr(32'h203, 8'hBB, 0);
        ev_a.delete(); ev_d.delete();
        in_progress = 1'b0;
        tick(0);
        drain(0, ok);
        n_checks++;
        if (!ok || obs.size() != 2) begin
            n_fail++;
            $display("FAIL partial_count: drained=%b transfers=%0d, want 1 2", ok, obs.size());
        end else begin
            n_checks++;
            if (obs[0].addr !== 32'h201 || obs[0].size !== 3'd0 || obs[0].data[15:8] !== 8'hAA) begin
                n_fail++;
                $display("FAIL partial_first: addr=%h size=%0d data=%h, want 00000201 0 lane1=aa",
                         obs[0].addr, obs[0].size, obs[0].data);
            end
            n_checks++;
            if (obs[1].addr !== 32'h203 || obs[1].size !== 3'd0 || obs[1].data[31:24] !== 8'hBB) begin
                n_fail++;
                $display("FAIL partial_second: addr=%h size=%0d data=%h, want 00000203 0 lane3=bb",
                         obs[1].addr, obs[1].size, obs[1].data);
            end
        end
    endtask

    task automatic test_jump();
        bit ok;
        obs.delete();
        in_progress = 1'b1;
        bus.HREADY = 1'b1;
        wr(32'h300, 8'hAA, 0);
        wr(32'h400, 8'h55, 0);
        ev_a.delete(); ev_d.delete();
        for (int i = 0; i < 4; i++) tick(0);
        n_checks++;
        if (obs.size() != 1 || obs[0].addr !== 32'h300 || obs[0].size !== 3'd0 ||
            obs[0].data[7:0] !== 8'hAA || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL jump_flush: transfers=%0d busy=%b, want one byte write aa@00000300 and busy 1",
                     obs.size(), busy);
        end
        in_progress = 1'b0;
        tick(0);
        drain(0, ok);
        n_checks++;
        if (!ok || obs.size() != 2 || obs[1].addr !== 32'h400 || obs[1].size !== 3'd0 ||
            obs[1].data[7:0] !== 8'h55) begin
            n_fail++;
            $display("FAIL jump_tail: drained=%b transfers=%0d, want 1 and second write 55@00000400",
                     ok, obs.size());
        end
    endtask

    task automatic test_wait_states();
        logic [7:0] d[4];
        logic [31:0] want;
        obs.delete();
        for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
        want = {d[3], d[2], d[1], d[0]};
        in_progress = 1'b1;
        bus.HREADY = 1'b0;
        for (int i = 0; i < 4; i++) wr(32'h1000 + 32'(i), d[i], 0);
        ev_a.delete(); ev_d.delete();
        for (int c = 1; c <= 9; c++) begin
            bus.HREADY = (c == 5 || c == 8);
            @(negedge clock);
            if (c >= 2 && c <= 5) begin
                n_checks++;
                if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h1000 || bus.HSIZE !== 3'd2) begin
                    n_fail++;
                    $display("FAIL wait_addr c%0d: HTRANS=%0d HADDR=%h HSIZE=%0d, want 2 00001000 2",
                             c, bus.HTRANS, bus.HADDR, bus.HSIZE);
                end
            end else if (c >= 6 && c <= 8) begin
                n_checks++;
                if (bus.HTRANS !== 2'b00 || bus.HWDATA !== want) begin
                    n_fail++;
                    $display("FAIL wait_data c%0d: HTRANS=%0d HWDATA=%h, want 0 %h", c, bus.HTRANS, bus.HWDATA, want);
                end
            end else if (c == 9) begin
                n_checks++;
                if (busy !== 1'b0 || obs.size() != 1) begin
                    n_fail++;
                    $display("FAIL wait_done: busy=%b transfers=%0d, want 0 1", busy, obs.size());
                end
            end
            @(posedge clock);
            #1;
        end
        bus.HREADY = 1'b1;
        in_progress = 1'b0;
        tick(0);
    endtask

    task automatic test_overflow();
        bit ok;
        obs.delete(); exp_q.delete(); ev_a.delete(); ev_d.delete();
        in_progress = 1'b1;
        bus.HREADY = 1'b0;
        for (int w = 0; w < 6; w++)
            for (int o = 0; o < 4; o++)
                wr(32'h2000 + 32'(4 * w + o), 8'($urandom), 0);
        for (int i = 0; i < 4; i++) begin
            void'(ev_a.pop_back());
            void'(ev_d.pop_back());
        end
        model_build(1'b0);
        tick(0);
        n_checks++;
        if (overflow !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: overflow=%b busy=%b, want 1 1", overflow, busy);
        end
        bus.HREADY = 1'b1;
        drain(0, ok);
        n_checks++;
        if (!ok || obs.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL ovf_count: drained=%b transfers=%0d, want 1 %0d", ok, obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_checks++;
            if (obs[i].addr !== exp_q[i].addr || obs[i].size !== exp_q[i].size ||
                obs[i].wr !== exp_q[i].wr || (obs[i].data & exp_q[i].dmask) !== exp_q[i].data) begin
                n_fail++;
                $display("FAIL ovf_xfer%0d: got addr=%h size=%0d data=%h, want addr=%h size=%0d data=%h",
                         i, obs[i].addr, obs[i].size, obs[i].data, exp_q[i].addr, exp_q[i].size, exp_q[i].data);
            end
        end
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: overflow=%b, want 1", overflow);
        end
        // Stall a fresh word in its address phase, then reset.
        bus.HREADY = 1'b0;
        for (int o = 0; o < 4; o++) wr(32'h3000 + 32'(o), 8'($urandom), 0);
        ev_a.delete(); ev_d.delete();
        tick(0);
        tick(0);
        n_checks++;
        if (bus.HTRANS !== 2'b10) begin
            n_fail++;
            $display("FAIL ovf_stall: HTRANS=%0d, want 2", bus.HTRANS);
        end
        reset = 1'b1;
        tick(0);
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (bus.HTRANS !== 2'b00 || busy !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_reset: HTRANS=%0d busy=%b overflow=%b, want 0 0 0", bus.HTRANS, busy, overflow);
        end
        bus.HREADY = 1'b1;
        in_progress = 1'b0;
        tick(0);
        obs.delete(); exp_q.delete();
    endtask

    // Bursts of at most four words so the FIFO plus issue register never overflow.
    task automatic test_random();
        bit ok;
        logic [29:0] w0;
        logic [3:0]  m;
        int nw, st, first;
        for (int b = 0; b < 40; b++) begin
            obs.delete(); exp_q.delete(); ev_a.delete(); ev_d.delete();
            big_endian = $urandom_range(0, 1);
            in_progress = 1'b1;
            tick(1);
            nw = $urandom_range(1, 4);
            w0 = 30'($urandom);
            for (int k = 0; k < nw; k++) begin
                m = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(1, 15));
                st = $urandom_range(0, 3);
                first = -1;
                for (int j = 0; j < 4; j++) begin
                    int off;
                    off = (st + j) % 4;
                    if (m[off]) begin
                        wr({w0 + 30'(k), 2'(off)}, 8'($urandom), 1);
                        if (first < 0) begin
                            first = off;
                            if ($urandom_range(0, 3) == 0)
                                wr({w0 + 30'(k), 2'(off)}, 8'($urandom), 1);
                        end
                        for (int g = $urandom_range(0, 1); g > 0; g--) tick(1);
                    end
                end
            end
            in_progress = 1'b0;
            tick(1);
            model_build(big_endian);
            drain(1, ok);
            n_checks++;
            if (!ok || obs.size() != exp_q.size() || overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL rand%0d_count: drained=%b transfers=%0d overflow=%b, want 1 %0d 0",
                         b, ok, obs.size(), overflow, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
                n_checks++;
                if (obs[i].addr !== exp_q[i].addr || obs[i].size !== exp_q[i].size ||
                    obs[i].wr !== exp_q[i].wr || (obs[i].data & exp_q[i].dmask) !== exp_q[i].data) begin
                    n_fail++;
                    $display("FAIL rand%0d_xfer%0d: got addr=%h size=%0d data=%h, want addr=%h size=%0d data=%h",
                             b, i, obs[i].addr, obs[i].size, obs[i].data,
                             exp_q[i].addr, exp_q[i].size, exp_q[i].data);
                end
            end
        end
        big_endian = 1'b0;
    endtask

    initial begin
        bus.HREADY = 1'b1;
        test_reset();
        test_aligned(1'b0, 32'h4433_2211);
        test_aligned(1'b1, 32'h1122_3344);
        test_partial();
        test_jump();
        test_wait_states();
        test_overflow();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
